pc_sequencer: RTL and testbench

- Fetch/execute controller that owns the 11-bit program counter and decides every PC update: sequential increment, absolute jump, relative subroutine call, return, conditional branch, halt.
- Keeps a hardware return-address stack and issues a request/ready fetch handshake to program memory.
- Accepts an external debug load of the PC.
- Sits between program memory and the instruction decoder; the decoder supplies the op class and condition.

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/wait/exec loop with a return-address stack,
// conditional branch, halt and debug PC load.
module pc_sequencer #(
  parameter int              PC_W        = 11,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           mem_req,
  output logic [PC_W-1:0]                mem_addr,
  input  logic                           mem_ready,
  input  logic [2:0]                     mem_op,
  input  logic [PC_W-1:0]                mem_arg,
  input  logic                           cond_z,
  input  logic                           load,
  input  logic [PC_W-1:0]                load_addr,
  output logic [PC_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           halted,
  output logic                           stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int IX_W = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JSR  = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_BRZ  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [2:0]        op_q;
  logic [PC_W-1:0]   arg_q;
  logic [PC_W-1:0]   stack_mem [STACK_DEPTH];
  logic [PC_W-1:0]   pc_n;
  logic [SP_W-1:0]   sp_n;
  logic [SP_W-1:0]   sp_dec;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jsr_off;
  logic              push;
  logic              err_set;
  logic              latch;

  assign pc_inc  = pc + PC_W'(1);
  assign sp_dec  = sp - SP_W'(1);
  // JSR offset lives in the low 10 bits of the argument, two's complement.
  assign jsr_off = {{(PC_W-10){arg_q[9]}}, arg_q[9:0]};

  // Request is held for exactly the WAIT state, so reset drops it at once.
  assign mem_req  = (state == WAIT);
  assign mem_addr = pc;
  assign halted   = (state == HALT);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    sp_n    = sp;
    push    = 1'b0;
    err_set = 1'b0;
    latch   = 1'b0;
    case (state)
      FETCH: begin
        if (load) pc_n = load_addr;
        else      state_n = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          latch   = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = FETCH;
        case (op_q)
          OP_JMP: pc_n = arg_q;
          OP_JSR: begin
            if (sp == SP_W'(STACK_DEPTH)) begin
              err_set = 1'b1;
              state_n = HALT;
            end else begin
              push = 1'b1;
              sp_n = sp + SP_W'(1);
              pc_n = pc + jsr_off;
            end
          end
          OP_RET: begin
            if (sp == '0) begin
              err_set = 1'b1;
              state_n = HALT;
            end else begin
              sp_n = sp_dec;
              pc_n = stack_mem[sp_dec[IX_W-1:0]];
            end
          end
          OP_BRZ:  pc_n = cond_z ? arg_q : pc_inc;
          OP_HALT: state_n = HALT;
          default: pc_n = pc_inc;
        endcase
      end
      HALT: begin
        if (load) begin
          pc_n    = load_addr;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_VEC;
      sp        <= '0;
      stack_err <= 1'b0;
      op_q      <= OP_NOP;
      arg_q     <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      sp    <= sp_n;
      if (err_set) stack_err <= 1'b1;
      if (latch) begin
        op_q  <= mem_op;
        arg_q <= mem_arg;
      end
    end
  end

  // Stack contents are only ever read below sp, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[IX_W-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: instruction sequencing, stack, branch,
// halt/load and asynchronous reset behaviour.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_ready;
  logic [2:0]  mem_op;
  logic [10:0] mem_arg;
  logic        cond_z;
  logic        load;
  logic [10:0] load_addr;
  logic [10:0] pc;
  logic [2:0]  sp;
  logic        halted;
  logic        stack_err;

  int checks;
  int failures;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_op    (mem_op),
    .mem_arg   (mem_arg),
    .cond_z    (cond_z),
    .load      (load),
    .load_addr (load_addr),
    .pc        (pc),
    .sp        (sp),
    .halted    (halted),
    .stack_err (stack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
  task automatic do_instr(input string tag, input logic [2:0] op, input logic [10:0] arg,
                          input logic cz, input logic [10:0] cur_pc, input logic [10:0] nxt_pc);
    @(posedge clk); @(negedge clk);
    chk({tag, "_wait_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_wait_addr"}, 32'(mem_addr), 32'(cur_pc));
    mem_ready = 1'b1;
    mem_op    = op;
    mem_arg   = arg;
    cond_z    = cz;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    mem_op    = 3'b000;
    mem_arg   = '0;
    chk({tag, "_exec_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_exec_pc"}, 32'(pc), 32'(cur_pc));
    @(posedge clk); @(negedge clk);
    cond_z = 1'b0;
    chk({tag, "_next_pc"}, 32'(pc), 32'(nxt_pc));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    mem_op    = 3'b000;
    mem_arg   = '0;
    cond_z    = 1'b0;
    load      = 1'b0;
    load_addr = '0;

    // reset state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(stack_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("fetch0_req", 32'(mem_req), 32'd0);

    // three NOPs from reset
    do_instr("nop0", 3'b000, 11'd0, 1'b0, 11'd0, 11'd1);
    do_instr("nop1", 3'b000, 11'd0, 1'b0, 11'd1, 11'd2);
    do_instr("nop2", 3'b000, 11'd0, 1'b0, 11'd2, 11'd3);
    chk("nop_sp", 32'(sp), 32'd0);

    // JMP to 10, JSR -10, RET
    do_instr("jmp10", 3'b001, 11'd10, 1'b0, 11'd3, 11'd10);
    do_instr("jsr_neg", 3'b010, 11'h3F6, 1'b0, 11'd10, 11'd0);
    chk("jsr_sp", 32'(sp), 32'd1);
    do_instr("ret", 3'b011, 11'd0, 1'b0, 11'd0, 11'd11);
    chk("ret_sp", 32'(sp), 32'd0);

    // BRZ not taken / taken, wrap, reserved op
    do_instr("brz_nt", 3'b100, 11'd100, 1'b0, 11'd11, 11'd12);
    do_instr("brz_t", 3'b100, 11'd100, 1'b1, 11'd12, 11'd100);
    do_instr("jmp_top", 3'b001, 11'd2047, 1'b0, 11'd100, 11'd2047);
    do_instr("nop_wrap", 3'b000, 11'd0, 1'b0, 11'd2047, 11'd0);
    do_instr("rsv101", 3'b101, 11'd500, 1'b1, 11'd0, 11'd1);
    do_instr("rsv110", 3'b110, 11'd500, 1'b1, 11'd1, 11'd2);

    // fill stack with JSR +5, then overflow
    do_instr("jsr_a", 3'b010, 11'd5, 1'b0, 11'd2, 11'd7);
    do_instr("jsr_b", 3'b010, 11'd5, 1'b0, 11'd7, 11'd12);
    do_instr("jsr_c", 3'b010, 11'd5, 1'b0, 11'd12, 11'd17);
    do_instr("jsr_d", 3'b010, 11'd5, 1'b0, 11'd17, 11'd22);
    chk("full_sp", 32'(sp), 32'd4);
    chk("full_err", 32'(stack_err), 32'd0);
    do_instr("jsr_ovf", 3'b010, 11'd5, 1'b0, 11'd22, 11'd22);
    chk("ovf_sp", 32'(sp), 32'd4);
    chk("ovf_err", 32'(stack_err), 32'd1);
    chk("ovf_halted", 32'(halted), 32'd1);
    chk("ovf_req", 32'(mem_req), 32'd0);
    repeat (3) @(negedge clk);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd22);

    // load out of HALT
    load      = 1'b1;
    load_addr = 11'd50;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    chk("load_pc", 32'(pc), 32'd50);
    chk("load_halted", 32'(halted), 32'd0);
    chk("load_err", 32'(stack_err), 32'd1);
    chk("load_sp", 32'(sp), 32'd4);

    // unwind in LIFO order
    do_instr("ret_a", 3'b011, 11'd0, 1'b0, 11'd50, 11'd18);
    do_instr("ret_b", 3'b011, 11'd0, 1'b0, 11'd18, 11'd13);
    do_instr("ret_c", 3'b011, 11'd0, 1'b0, 11'd13, 11'd8);
    do_instr("ret_d", 3'b011, 11'd0, 1'b0, 11'd8, 11'd3);
    chk("unwind_sp", 32'(sp), 32'd0);

    // HALT op, then load back out
    do_instr("halt_op", 3'b111, 11'd0, 1'b0, 11'd3, 11'd3);
    chk("halt_op_halted", 32'(halted), 32'd1);
    load      = 1'b1;
    load_addr = 11'd9;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    chk("halt_op_load", 32'(pc), 32'd9);

    // underflow from a clean reset
    apply_reset();
    chk("uf_pre_err", 32'(stack_err), 32'd0);
    do_instr("ret_uf", 3'b011, 11'd0, 1'b0, 11'd0, 11'd0);
    chk("uf_err", 32'(stack_err), 32'd1);
    chk("uf_halted", 32'(halted), 32'd1);
    chk("uf_sp", 32'(sp), 32'd0);

    // long WAIT with a load pulse that must be ignored
    apply_reset();
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      load      = (i >= 2 && i <= 4);
      load_addr = 11'd300;
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'd0);
    end
    @(negedge clk);
    load      = 1'b0;
    mem_ready = 1'b1;
    mem_op    = 3'b000;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    chk("stall_exec_pc", 32'(pc), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("stall_next_pc", 32'(pc), 32'd1);

    // load in FETCH beats the FETCH->WAIT transition
    load      = 1'b1;
    load_addr = 11'd77;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    chk("fload_pc", 32'(pc), 32'd77);
    chk("fload_req", 32'(mem_req), 32'd0);
    do_instr("after_fload", 3'b000, 11'd0, 1'b0, 11'd77, 11'd78);

    // async reset in the middle of WAIT
    do_instr("jmp500", 3'b001, 11'd500, 1'b0, 11'd78, 11'd500);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    mem_op    = 3'b001;
    mem_arg   = 11'd900;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    mem_op    = 3'b000;
    mem_arg   = '0;
    chk("post_rst_pc", 32'(pc), 32'd0);
    do_instr("post_rst", 3'b000, 11'd0, 1'b0, 11'd0, 11'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
